// File: rtl/spi_cfg_sequencer_pkg.sv
// Shared definitions for the SPI configuration sequencer and the SPI write
// master it feeds: sequencer state encoding and transfer-length helpers.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_RD,
    LOAD,
    XFER,
    GAP,
    FIN
  } seq_state_t;

  // Load-to-next-legal-load distance of the SPI master for 16-bit words.
  localparam int SEQ_XFER_CYCLES_16 = 35;

  // Cycles the SPI master needs for one word of the given width.
  function automatic int xfer_cycles(input int width);
    return 2 * width + 3;
  endfunction

endpackage

// File: rtl/spi_cfg_sequencer_if.sv
// Table-read and SPI-write-master signals of the configuration sequencer.
// master: the sequencer side; slave: the table storage and SPI master side.
interface spi_cfg_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int GAP_WIDTH  = 8,
  parameter int ADDR_WIDTH = 6
);

  logic                            tbl_rd;
  logic [ADDR_WIDTH-1:0]           tbl_addr;
  logic [GAP_WIDTH+DATA_WIDTH-1:0] tbl_data;
  logic [DATA_WIDTH-1:0]           spi_wdat;
  logic                            spi_load;
  logic                            spi_busy;

  modport master (
    output tbl_rd,
    output tbl_addr,
    output spi_wdat,
    output spi_load,
    input  tbl_data,
    input  spi_busy
  );

  modport slave (
    input  tbl_rd,
    input  tbl_addr,
    input  spi_wdat,
    input  spi_load,
    output tbl_data,
    output spi_busy
  );

endinterface

// File: rtl/spi_seq_counter.sv
// Loadable down-counter with a zero flag. Used by the sequencer for the
// post-load guard interval and for the per-entry inter-word gap.
module spi_seq_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load takes priority over decrement; the count rests at zero.
  always_ff @(posedge clk or negedge arstn) begin
    // NOTE: clocked state uses <= so every flop samples pre-edge values.
    if (!arstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/spi_cfg_sequencer.sv
// SPI configuration sequencer: walks an external table of {gap, word}
// entries and hands each word to the SPI write master, honouring the
// master's transfer time, its busy flag and a per-entry idle gap.
module spi_cfg_sequencer
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int GAP_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 6,
  parameter int XFER_CYCLES = xfer_cycles(DATA_WIDTH)
) (
  input  logic                clk,
  input  logic                arstn,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_WIDTH:0] n_entries,
  spi_cfg_sequencer_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [ADDR_WIDTH:0] idx
);

  localparam int GUARD_WIDTH = $clog2(XFER_CYCLES);

  seq_state_t            state;
  logic [ADDR_WIDTH:0]   n_latched;
  logic [GAP_WIDTH-1:0]  gap_q;
  logic                  abort_seen;
  logic                  tbl_rd_q;
  logic [ADDR_WIDTH-1:0] tbl_addr_q;
  logic [DATA_WIDTH-1:0] spi_wdat_q;
  logic                  spi_load_q;
  logic                  guard_zero;
  logic                  gap_zero;
  logic                  xfer_exit;
  logic                  step_now;

  // The word is finished once the guard time has run out and the master is idle.
  assign xfer_exit = (state == XFER) && guard_zero && !bus.spi_busy;
  // Point at which the next entry, the end of the walk, or an abort is decided.
  assign step_now  = (xfer_exit && gap_q == '0) || (state == GAP && gap_zero);

  spi_seq_counter #(.WIDTH(GUARD_WIDTH)) u_guard (
    .clk      (clk),
    .arstn    (arstn),
    .load     (state == LOAD),
    .load_val (GUARD_WIDTH'(XFER_CYCLES - 1)),
    .dec      (state == XFER),
    .zero     (guard_zero)
  );

  spi_seq_counter #(.WIDTH(GAP_WIDTH)) u_gap (
    .clk      (clk),
    .arstn    (arstn),
    .load     (xfer_exit && gap_q != '0),
    .load_val (gap_q - GAP_WIDTH'(1)),
    .dec      (state == GAP),
    .zero     (gap_zero)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state      <= IDLE;
      n_latched  <= '0;
      gap_q      <= '0;
      abort_seen <= 1'b0;
      tbl_rd_q   <= 1'b0;
      tbl_addr_q <= '0;
      spi_wdat_q <= '0;
      spi_load_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      idx        <= '0;
    end else begin
      // NOTE: one-cycle strobes default low here and are raised only where needed.
      tbl_rd_q   <= 1'b0;
      spi_load_q <= 1'b0;
      done       <= 1'b0;

      if (state != IDLE && abort) begin
        abort_seen <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            n_latched  <= n_entries;
            idx        <= '0;
            aborted    <= 1'b0;
            abort_seen <= 1'b0;
            busy       <= 1'b1;
            if (n_entries == '0) begin
              state <= FIN;
            end else begin
              state      <= FETCH;
              tbl_rd_q   <= 1'b1;
              tbl_addr_q <= '0;
            end
          end
        end
        FETCH: begin
          state <= WAIT_RD;
        end
        WAIT_RD: begin
          spi_wdat_q <= bus.tbl_data[DATA_WIDTH-1:0];
          gap_q      <= bus.tbl_data[GAP_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
          spi_load_q <= 1'b1;
          state      <= LOAD;
        end
        LOAD: begin
          idx   <= idx + (ADDR_WIDTH + 1)'(1);
          state <= XFER;
        end
        XFER: begin
          if (xfer_exit && gap_q != '0) begin
            state <= GAP;
          end
        end
        GAP: begin
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (step_now) begin
        if (abort_seen || abort) begin
          aborted <= 1'b1;
          state   <= FIN;
        end else if (idx == n_latched) begin
          state <= FIN;
        end else begin
          state      <= FETCH;
          tbl_rd_q   <= 1'b1;
          tbl_addr_q <= idx[ADDR_WIDTH-1:0];
        end
      end
    end
  end

  assign bus.tbl_rd   = tbl_rd_q;
  assign bus.tbl_addr = tbl_addr_q;
  assign bus.spi_wdat = spi_wdat_q;
  assign bus.spi_load = spi_load_q;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Testbench for spi_cfg_sequencer: a table model with 1-cycle read latency,
// an SPI master model that stays busy for a set number of cycles after each
// load, and a reference model that predicts load/read/done timing per walk.
`timescale 1ns/1ps
module tb_spi_cfg_sequencer;

  localparam int DW   = 16;
  localparam int GW   = 8;
  localparam int AW   = 6;
  localparam int XFER = 35;

  logic          clk       = 1'b0;
  logic          arstn     = 1'b0;
  logic          start     = 1'b0;
  logic          abort     = 1'b0;
  logic [AW:0]   n_entries = '0;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [AW:0]   idx;

  spi_cfg_sequencer_if #(.DATA_WIDTH(DW), .GAP_WIDTH(GW), .ADDR_WIDTH(AW)) bus_if ();

  spi_cfg_sequencer #(
    .DATA_WIDTH (DW),
    .GAP_WIDTH  (GW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .arstn     (arstn),
    .start     (start),
    .abort     (abort),
    .n_entries (n_entries),
    .bus       (bus_if),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .idx       (idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Table storage: registered read, data valid the cycle after tbl_rd.
  logic [GW+DW-1:0] tbl_mem [64];
  always @(posedge clk) if (bus_if.tbl_rd) bus_if.tbl_data <= tbl_mem[bus_if.tbl_addr];

  // SPI master: busy for spi_busy_len cycles after every load.
  int spi_busy_len = 34;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (bus_if.spi_load) busy_cnt <= spi_busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus_if.spi_busy = (busy_cnt != 0);

  // Observed events, sampled mid-cycle.
  int          ld_cyc[$];
  logic [DW-1:0] ld_word[$];
  int          rd_cyc[$];
  int          rd_addr[$];
  int          busy_cycles = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  logic        done_busy = 1'b0;
  always @(negedge clk) begin
    if (bus_if.spi_load) begin ld_cyc.push_back(cyc); ld_word.push_back(bus_if.spi_wdat); end
    if (bus_if.tbl_rd) begin rd_cyc.push_back(cyc); rd_addr.push_back(int'(bus_if.tbl_addr)); end
    if (busy) busy_cycles++;
    if (done) begin
      done_cnt++;
      if (done_cnt == 1) begin done_cyc = cyc; done_busy = busy; end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: expected loads, done cycle, idx and aborted for one walk.
  int            exp_ld_cyc[$];
  logic [DW-1:0] exp_ld_word[$];
  int            exp_done;
  int            exp_idx;
  logic          exp_aborted;

  task automatic model_walk(input int t0, input int n, input int busy_len, input int abort_at);
    int load_c, exit_c, dec_c;
    exp_ld_cyc.delete();
    exp_ld_word.delete();
    exp_idx     = 0;
    exp_aborted = 1'b0;
    exp_done    = t0 + 2;
    load_c      = t0 + 3;
    for (int k = 0; k < n; k++) begin
      exp_ld_cyc.push_back(load_c);
      exp_ld_word.push_back(tbl_mem[k][DW-1:0]);
      exp_idx  = k + 1;
      exit_c   = load_c + ((busy_len + 1 > XFER) ? busy_len + 1 : XFER);
      dec_c    = exit_c + int'(tbl_mem[k][GW+DW-1:DW]);
      exp_done = dec_c + 2;
      if (abort_at >= 0 && abort_at <= dec_c) begin
        exp_aborted = 1'b1;
        break;
      end
      load_c = dec_c + 3;
    end
  endtask

  // Run one walk: start (optionally with abort), optional abort/restart pulses
  // later, then compare everything observed with the reference model.
  task automatic run_walk(input string name, input int n, input int abort_off,
                          input int restart_off, input int restart_n);
    int t0;
    ld_cyc.delete(); ld_word.delete(); rd_cyc.delete(); rd_addr.delete();
    busy_cycles = 0; done_cnt = 0; done_cyc = -1;
    @(posedge clk); #1;
    n_entries = (AW+1)'(n);
    start = 1'b1;
    abort = (abort_off == 0);
    t0 = cyc;
    model_walk(t0, n, spi_busy_len, (abort_off > 0) ? t0 + abort_off : -1);
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      abort = (abort_off > 0 && cyc == t0 + abort_off);
      start = (restart_off > 0 && cyc == t0 + restart_off);
      if (start) n_entries = (AW+1)'(restart_n);
      @(posedge clk); #1;
    end
    abort = 1'b0;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cnt == 0) begin
      n_bad++; $display("FAIL %s timeout: no done within budget, got 0 done pulses required 1", name);
    end
    n_cmp++;
    if (ld_cyc.size() != exp_ld_cyc.size()) begin
      n_bad++; $display("FAIL %s load count: got %0d required %0d", name, ld_cyc.size(), exp_ld_cyc.size());
    end
    for (int k = 0; k < ld_cyc.size() && k < exp_ld_cyc.size(); k++) begin
      n_cmp++;
      if (ld_cyc[k] - t0 != exp_ld_cyc[k] - t0 || ld_word[k] !== exp_ld_word[k]) begin
        n_bad++;
        $display("FAIL %s load[%0d]: got cycle +%0d word %h required cycle +%0d word %h",
                 name, k, ld_cyc[k] - t0, ld_word[k], exp_ld_cyc[k] - t0, exp_ld_word[k]);
      end
    end
    n_cmp++;
    if (rd_cyc.size() != exp_ld_cyc.size()) begin
      n_bad++; $display("FAIL %s tbl_rd count: got %0d required %0d", name, rd_cyc.size(), exp_ld_cyc.size());
    end
    for (int k = 0; k < rd_cyc.size() && k < exp_ld_cyc.size(); k++) begin
      n_cmp++;
      if (rd_cyc[k] != exp_ld_cyc[k] - 2 || rd_addr[k] != k) begin
        n_bad++;
        $display("FAIL %s tbl_rd[%0d]: got cycle +%0d addr %0d required cycle +%0d addr %0d",
                 name, k, rd_cyc[k] - t0, rd_addr[k], exp_ld_cyc[k] - 2 - t0, k);
      end
    end
    n_cmp++;
    if (done_cnt != 1 || done_cyc != exp_done || done_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done: got %0d pulses at +%0d busy=%b required 1 pulse at +%0d busy=0",
               name, done_cnt, done_cyc - t0, done_busy, exp_done - t0);
    end
    n_cmp++;
    if (busy_cycles != exp_done - t0 - 1) begin
      n_bad++; $display("FAIL %s busy length: got %0d required %0d", name, busy_cycles, exp_done - t0 - 1);
    end
    n_cmp++;
    if (idx !== (AW+1)'(exp_idx) || aborted !== exp_aborted) begin
      n_bad++;
      $display("FAIL %s idx/aborted: got %0d/%b required %0d/%b", name, idx, aborted, exp_idx, exp_aborted);
    end
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, aborted, bus_if.spi_load, bus_if.tbl_rd} !== 5'b0 || idx !== '0 ||
        bus_if.tbl_addr !== '0 || bus_if.spi_wdat !== '0) begin
      n_bad++;
      $display("FAIL reset outputs: got busy=%b done=%b aborted=%b load=%b rd=%b idx=%0d addr=%0d wdat=%h required all 0",
               busy, done, aborted, bus_if.spi_load, bus_if.tbl_rd, idx, bus_if.tbl_addr, bus_if.spi_wdat);
    end
    arstn = 1'b1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || aborted !== 1'b0 || bus_if.tbl_rd !== 1'b0 || bus_if.spi_load !== 1'b0) begin
      n_bad++;
      $display("FAIL idle quiet: got busy=%b aborted=%b rd=%b load=%b required 0000",
               busy, aborted, bus_if.tbl_rd, bus_if.spi_load);
    end
  endtask

  task automatic test_three_entries();
    tbl_mem[0] = {8'd0, 16'hA5A5};
    tbl_mem[1] = {8'd4, 16'h1234};
    tbl_mem[2] = {8'd0, 16'hFFFF};
    spi_busy_len = 34;
    run_walk("three_entries", 3, -1, -1, 0);
    n_cmp++;
    if (ld_cyc.size() < 3) begin
      n_bad++; $display("FAIL three_entries spacing: got %0d loads required 3", ld_cyc.size());
    end else if (ld_cyc[1] - ld_cyc[0] != 38 || ld_cyc[2] - ld_cyc[1] != 42) begin
      n_bad++;
      $display("FAIL three_entries spacing: got %0d,%0d required 38,42", ld_cyc[1] - ld_cyc[0], ld_cyc[2] - ld_cyc[1]);
    end
    n_cmp++;
    if (idx !== 7'd3) begin
      n_bad++; $display("FAIL three_entries idx: got %0d required 3", idx);
    end
  endtask

  task automatic test_zero_entries();
    run_walk("zero_entries", 0, -1, -1, 0);
  endtask

  task automatic test_abort();
    for (int k = 0; k < 5; k++) tbl_mem[k] = {8'd0, 16'(16'h0100 + k)};
    spi_busy_len = 34;
    run_walk("abort_mid", 5, 13, -1, 0);
    n_cmp++;
    if (aborted !== 1'b1 || idx !== 7'd1 || ld_cyc.size() != 1) begin
      n_bad++;
      $display("FAIL abort_mid result: got aborted=%b idx=%0d loads=%0d required 1/1/1", aborted, idx, ld_cyc.size());
    end
    run_walk("abort_with_start", 2, 0, -1, 0);
  endtask

  task automatic test_slow_spi();
    tbl_mem[0] = {8'd0, 16'hC0DE};
    tbl_mem[1] = {8'd0, 16'h5EED};
    spi_busy_len = 60;
    run_walk("slow_spi", 2, -1, -1, 0);
    n_cmp++;
    if (ld_cyc.size() < 1 || rd_cyc.size() < 2) begin
      n_bad++; $display("FAIL slow_spi events: got %0d loads %0d reads required 2 and 2", ld_cyc.size(), rd_cyc.size());
    end else if (rd_cyc[1] < ld_cyc[0] + 62) begin
      n_bad++; $display("FAIL slow_spi next read: got +%0d after load required >= +62", rd_cyc[1] - ld_cyc[0]);
    end
    spi_busy_len = 34;
  endtask

  task automatic test_restart_ignored();
    tbl_mem[0] = {8'd1, 16'h1111};
    tbl_mem[1] = {8'd0, 16'h2222};
    run_walk("restart_ignored", 2, -1, 20, 5);
    n_cmp++;
    if (idx !== 7'd2) begin
      n_bad++; $display("FAIL restart_ignored idx: got %0d required 2", idx);
    end
  endtask

  task automatic test_random_walks();
    for (int w = 0; w < 6; w++) begin
      int n, ab;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        tbl_mem[k] = {8'($urandom_range(0, 1) ? $urandom_range(1, 6) : 0), 16'($urandom)};
      end
      spi_busy_len = $urandom_range(5, 50);
      ab = $urandom_range(0, 1) ? $urandom_range(1, 150) : -1;
      run_walk($sformatf("random_%0d", w), n, ab, -1, 0);
    end
    spi_busy_len = 34;
  endtask

  task automatic test_reset_in_gap();
    tbl_mem[0] = {8'd20, 16'hBEEF};
    tbl_mem[1] = {8'd0, 16'h7777};
    spi_busy_len = 34;
    @(posedge clk); #1;
    n_entries = 7'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (44) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b1 || idx !== 7'd1 || bus_if.spi_wdat !== 16'hBEEF) begin
      n_bad++; $display("FAIL gap_reset pre: got busy=%b idx=%0d wdat=%h required 1/1/beef", busy, idx, bus_if.spi_wdat);
    end
    arstn = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, aborted, bus_if.spi_load, bus_if.tbl_rd} !== 5'b0 || idx !== '0 ||
        bus_if.tbl_addr !== '0 || bus_if.spi_wdat !== '0) begin
      n_bad++;
      $display("FAIL gap_reset async: got busy=%b done=%b aborted=%b load=%b rd=%b idx=%0d addr=%0d wdat=%h required all 0",
               busy, done, aborted, bus_if.spi_load, bus_if.tbl_rd, idx, bus_if.tbl_addr, bus_if.spi_wdat);
    end
    @(posedge clk); #1;
    arstn = 1'b1;
    tbl_mem[0] = {8'd0, 16'h0F0F};
    run_walk("after_reset", 2, -1, -1, 0);
  endtask

  initial begin
    for (int k = 0; k < 64; k++) tbl_mem[k] = '0;
    test_reset();
    test_three_entries();
    test_zero_entries();
    test_abort();
    test_slow_spi();
    test_restart_ignored();
    test_random_walks();
    test_reset_in_gap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
